uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter among N_REQ byte sources. It accepts bytes over per-requester valid/ready handshakes and issues one-cycle `tx_start` pulses with the byte on `tx_din`. It waits for `tx_done_tick` before launching the next byte. Requesters can lock the transmitter for multi-byte messages using `req_last`; an optional timeout breaks stalled locks. It sits between the protocol/message sources and `uart_tx`.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- LOCK_TIMEOUT, 1023: idle cycles a locked requester may stall before the lock is released; 0 means never release.

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  N_REQ  requester i has a byte on req_data[8i+7:8i]
- req_data  in  8*N_REQ  packed bytes, requester i at [8i+7:8i]
- req_last  in  N_REQ  byte offered by requester i is the last byte of its message
- req_ready  out  N_REQ  one-hot accept; a byte transfers on an edge where req_valid[i] & req_ready[i]
- tx_start  out  1  one-cycle launch pulse to uart_tx
- tx_din  out  8  byte for uart_tx; stable from tx_start until tx_done_tick
- tx_done_tick  in  1  uart_tx frame complete, one cycle
- grant_valid  out  1  a requester currently owns the transmitter
- grant_id  out  clog2(N_REQ)  owning requester index
- lock_timeout  out  1  one-cycle pulse when a lock is broken by timeout

## Operation
- FSM states: IDLE, LAUNCH, WAIT_DONE, HOLD.
- IDLE:
  - If any req_valid, pick the first set bit scanning from rr_ptr upward with wrap: i = rr_ptr, rr_ptr+1, ..., N_REQ-1, 0, ...
  - req_ready[winner]=1 in the same cycle. req_ready is combinational from registered state and req_valid; it never depends on req_ready.
  - On that edge: capture req_data and req_last of the winner, grant_id<=winner, grant_valid<=1, go to LAUNCH.
- LAUNCH: tx_start=1 for exactly this cycle, then go to WAIT_DONE.
- WAIT_DONE: wait for tx_done_tick. On tx_done_tick:
  - captured last=1: rr_ptr<=grant_id+1 (mod N_REQ), grant_valid<=0, go to IDLE.
  - last=0 and req_valid[grant_id]=1: accept the next byte in this same cycle (req_ready[grant_id]=1), capture it, go to LAUNCH.
  - last=0 and req_valid[grant_id]=0: go to HOLD and clear the timeout counter.
- HOLD: only requester grant_id is served; others see req_ready=0.
  - req_valid[grant_id]: accept, capture, go to LAUNCH.
  - Else, if LOCK_TIMEOUT!=0 and the counter reaches LOCK_TIMEOUT-1: pulse lock_timeout, rr_ptr<=grant_id+1, grant_valid<=0, go to IDLE.
  - Else the counter increments.
- Timeout counter width is clog2(LOCK_TIMEOUT+1). It saturates and never wraps.
- tx_done_tick outside WAIT_DONE is ignored.
- tx_din holds the last captured byte at all times and changes only on accept edges.
- At most one bit of req_ready is set in any cycle. req_ready is all-zero in LAUNCH and WAIT_DONE, except in the done cycle described above.

## Timing
- Reset values: FSM=IDLE, rr_ptr=0, req_ready=0, tx_start=0, tx_din=8'h00, grant_valid=0, grant_id=0, lock_timeout=0, counter=0.
- Accept edge to tx_start: 1 cycle. Byte-to-byte gap inside a locked message: tx_done_tick cycle, then tx_start on the next cycle. This is legal because uart_tx is back in idle at that point.
- Release to the next grant: a requester's last byte done, then IDLE for 1 cycle with that cycle's accept, then LAUNCH.
- Simultaneous requests: resolved purely by rr_ptr; no starvation. Each waiting requester is served within N_REQ-1 messages of other requesters.
- Reset mid-operation returns the FSM to IDLE immediately with all outputs at reset values. uart_tx shares the reset; any partial frame is abandoned.
- A requester dropping req_valid while not accepted is legal. Once accepted, a byte is always transmitted.

## Test plan
- Single byte: req_valid[0]=1, data 8'hA5, last=1 -> req_ready[0] for 1 cycle, tx_start 1 cycle later with tx_din=A5. After tx_done_tick, grant_valid=0 and rr_ptr=1.
- Round-robin: all four requesters valid with last=1 from reset, bytes 10/11/12/13 -> tx_din sequence 10,11,12,13. Then re-requesting 0 and 2 gives 0 before 2, because rr_ptr=0 after 3.
- Locked message: req 1 sends 3 bytes (last on the 3rd) while req 0 and req 2 stay valid -> three consecutive frames from req 1 with no interleave. tx_start falls exactly 1 cycle after each tx_done_tick. Req 2 is served next.
- Lock timeout: LOCK_TIMEOUT=8, req 3 sends one byte with last=0 then idles, req 0 waiting -> lock_timeout pulses 8 cycles into HOLD and req 0 is accepted in the following IDLE cycle.
- Spurious done: tx_done_tick in IDLE and in LAUNCH -> no state change and no extra tx_start.
- Reset mid-frame: assert reset during WAIT_DONE of a locked message -> all outputs at reset values the same cycle; after release, the first grant goes to the lowest-index valid requester.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N_REQ byte sources,
// with per-message locking via req_last and an optional stall timeout.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int LOCK_TIMEOUT = 1023
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [8*N_REQ-1:0]         req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       tx_start,
  output logic [7:0]                 tx_din,
  input  logic                       tx_done_tick,
  output logic                       grant_valid,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       lock_timeout
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] LAST_ID = IW'(N_REQ - 1);
  localparam logic [CW-1:0] CNT_END =
    CW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE,
    HOLD
  } state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   pick_id;
  logic [IW-1:0]   take_id;
  logic [IW-1:0]   next_ptr;
  logic            pick_found;
  logic            take;
  logic            cap_last;
  logic            done_ev;
  logic            hold_exp;
  logic [CW-1:0]   cnt;
  logic [7:0]      take_byte;

  // Scan downward so the lowest offset from rr_ptr wins.
  always_comb begin : rr_scan
    int j;
    j          = 0;
    pick_found = 1'b0;
    pick_id    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (req_valid[IW'(j)]) begin
        pick_found = 1'b1;
        pick_id    = IW'(j);
      end
    end
  end

  assign done_ev  = (state == WAIT_DONE) && tx_done_tick;
  assign hold_exp = (LOCK_TIMEOUT != 0) && (cnt == CNT_END);
  assign next_ptr = (grant_id == LAST_ID) ? '0 : grant_id + IW'(1);

  always_comb begin
    take    = 1'b0;
    take_id = grant_id;
    unique case (1'b1)
      (state == IDLE): begin
        take    = pick_found;
        take_id = pick_id;
      end
      (state == HOLD): take = req_valid[grant_id];
      done_ev:         take = !cap_last && req_valid[grant_id];
      default: ;
    endcase
  end

  assign req_ready = (take && !reset) ? (N_REQ'(1) << take_id) : '0;
  assign take_byte = req_data[{take_id, 3'b000} +: 8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      tx_start     <= 1'b0;
      tx_din       <= 8'h00;
      grant_valid  <= 1'b0;
      grant_id     <= '0;
      lock_timeout <= 1'b0;
      cnt          <= '0;
      cap_last     <= 1'b0;
    end else begin
      tx_start     <= 1'b0;
      lock_timeout <= 1'b0;
      if (take) begin
        tx_din      <= take_byte;
        cap_last    <= req_last[take_id];
        grant_id    <= take_id;
        grant_valid <= 1'b1;
        tx_start    <= 1'b1;
        state       <= LAUNCH;
      end else begin
        unique case (state)
          LAUNCH: state <= WAIT_DONE;
          WAIT_DONE: begin
            if (tx_done_tick) begin
              if (cap_last) begin
                rr_ptr      <= next_ptr;
                grant_valid <= 1'b0;
                state       <= IDLE;
              end else begin
                cnt   <= '0;
                state <= HOLD;
              end
            end
          end
          HOLD: begin
            if (hold_exp) begin
              lock_timeout <= 1'b1;
              rr_ptr       <= next_ptr;
              grant_valid  <= 1'b0;
              state        <= IDLE;
            end else if (cnt != CNT_MAX) begin
              cnt <= cnt + CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
